// File: rtl/multicycle_control_fsm_if.sv
// Bundle of control/handshake signals between the multi-cycle control unit
// and the rest of the core (instruction register, memories, ALU, PC, reg file).
//
// master : the control unit (drives requests, enables and selects)
// slave  : the datapath / memory side (supplies opcode fields and ready flags)
//
// Signals
//   opcode, funct3        instruction-register fields
//   imem_ready            instruction memory returns data this cycle
//   dmem_ready            data memory completes the access this cycle
//   branch_taken          comparator result, valid in EXEC
//   imem_req, ir_write    fetch request / load instruction register
//   dmem_req, dmem_we     data access request / store write enable
//   mem_width             registered funct3 for load/store width
//   alu_src_a, alu_src_b  ALU operand selects (rs1/pc, rs2/imm)
//   alu_op                00 ADD, 01 SUB, 10 funct-decoded
//   reg_write, wb_sel     register write enable / writeback source
//   pc_write, pc_sel      PC update enable / next-PC source
//   retire                one-cycle pulse per completed instruction
//   trap, trap_cause      sticky trap flag and its cause
//   state_o               current FSM state, for debug
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       imem_ready;
    logic       dmem_ready;
    logic       branch_taken;
    logic       imem_req;
    logic       ir_write;
    logic       dmem_req;
    logic       dmem_we;
    logic [2:0] mem_width;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;
    logic [2:0] state_o;

    modport master (
        input  opcode, funct3, imem_ready, dmem_ready, branch_taken,
        output imem_req, ir_write, dmem_req, dmem_we, mem_width,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               pc_write, pc_sel, retire, trap, trap_cause, state_o
    );

    modport slave (
        output opcode, funct3, imem_ready, dmem_ready, branch_taken,
        input  imem_req, ir_write, dmem_req, dmem_we, mem_width,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               pc_write, pc_sel, retire, trap, trap_cause, state_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with variable-latency instruction and
// data memories, and parks in a sticky TRAP state on illegal opcodes,
// ECALL/EBREAK or a memory that never answers.
//
// Ports
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-high reset
//   bus     control/handshake bundle (master side), see the interface file
//
// Parameters
//   TIMEOUT_CYCLES  max wait cycles on a ready flag, 0 disables the watchdog
//   ILLEGAL_TRAP    1: unknown opcode traps, 0: it retires as a NOP
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | request instruction, load IR when imem_ready
// DECODE | capture opcode/funct3, screen for illegal opcodes
// EXEC   | drive ALU controls; branches/FENCE finish here
// MEM    | data access, wait for dmem_ready; stores finish here
// WB     | register-file write and PC update
// TRAP   | sticky; only reset leaves
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit ILLEGAL_TRAP   = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_SYSTEM  = 2'b10;
    localparam logic [1:0] CAUSE_BUS     = 2'b11;

    // A disabled watchdog still needs a 1-bit counter to keep widths legal.
    localparam int              CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   TO_VAL = CW'(TIMEOUT_CYCLES);

    state_t        r_state;
    state_t        w_next;
    logic [6:0]    r_opc;
    logic [2:0]    r_f3;
    logic [CW-1:0] r_wait_cnt;
    logic [1:0]    r_cause;
    logic [1:0]    w_cause_next;
    logic          w_timeout;
    logic          w_waiting;

    logic          w_imem_req;
    logic          w_ir_write;
    logic          w_dmem_req;
    logic          w_dmem_we;
    logic          w_alu_src_a;
    logic          w_alu_src_b;
    logic [1:0]    w_alu_op;
    logic          w_reg_write;
    logic [1:0]    w_wb_sel;
    logic          w_pc_write;
    logic [1:0]    w_pc_sel;
    logic          w_retire;
    logic          w_trap;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: is_legal = 1'b1;
            default:                               is_legal = 1'b0;
        endcase
    endfunction

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == TO_VAL);
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_FETCH;
            r_opc      <= '0;
            r_f3       <= '0;
            r_wait_cnt <= '0;
            r_cause    <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_next;
            if (r_state == S_DECODE) begin
                r_opc <= bus.opcode;
                r_f3  <= bus.funct3;
            end
            // Saturating wait counter, restarted on every state change.
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if ((TIMEOUT_CYCLES != 0) && w_waiting && (r_wait_cnt != TO_VAL)) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
        end
    end

    // ALU controls follow the latched opcode and are held through MEM so the
    // address computed in EXEC stays stable for the whole access.
    always_comb begin
        w_alu_op    = 2'b00;
        w_alu_src_a = 1'b0;
        w_alu_src_b = 1'b0;
        if ((r_state == S_EXEC) || (r_state == S_MEM)) begin
            case (r_opc)
                OP_R:               w_alu_op = 2'b10;
                OP_I: begin
                    w_alu_op    = 2'b10;
                    w_alu_src_b = 1'b1;
                end
                OP_LOAD, OP_STORE:  w_alu_src_b = 1'b1;
                OP_BRANCH:          w_alu_op = 2'b01;
                OP_AUIPC: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 1'b1;
                end
                OP_JALR:            w_alu_src_b = 1'b1;
                default: begin
                    w_alu_op    = 2'b00;
                    w_alu_src_a = 1'b0;
                    w_alu_src_b = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cause_next = r_cause;
        w_imem_req   = 1'b0;
        w_ir_write   = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_reg_write  = 1'b0;
        w_wb_sel     = 2'b00;
        w_pc_write   = 1'b0;
        w_pc_sel     = 2'b00;
        w_retire     = 1'b0;
        w_trap       = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                // Ready takes priority over a coincident timeout.
                if (bus.imem_ready) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_cause_next = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                if (is_legal(bus.opcode)) begin
                    w_next = S_EXEC;
                end else if (ILLEGAL_TRAP) begin
                    w_next       = S_TRAP;
                    w_cause_next = CAUSE_ILLEGAL;
                end else begin
                    w_pc_write = 1'b1;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_EXEC: begin
                case (r_opc)
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    OP_BRANCH: begin
                        w_pc_write = 1'b1;
                        w_pc_sel   = bus.branch_taken ? 2'b01 : 2'b00;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end
                    OP_FENCE: begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end
                    OP_SYSTEM: begin
                        w_next       = S_TRAP;
                        w_cause_next = CAUSE_SYSTEM;
                    end
                    default:           w_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_opc == OP_STORE);
                if (bus.dmem_ready) begin
                    if (r_opc == OP_STORE) begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_cause_next = CAUSE_BUS;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
                case (r_opc)
                    OP_LOAD:  w_wb_sel = 2'b01;
                    OP_JAL: begin
                        w_wb_sel = 2'b10;
                        w_pc_sel = 2'b10;
                    end
                    OP_JALR: begin
                        w_wb_sel = 2'b10;
                        w_pc_sel = 2'b11;
                    end
                    OP_LUI:   w_wb_sel = 2'b11;
                    default:  w_wb_sel = 2'b00;
                endcase
            end
            S_TRAP: begin
                w_trap = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset is synchronous, so the state register may still hold MEM/WB during
    // the reset cycle; gating here guarantees no access, write or retire leaks.
    assign bus.imem_req   = i_rst ? 1'b0  : w_imem_req;
    assign bus.ir_write   = i_rst ? 1'b0  : w_ir_write;
    assign bus.dmem_req   = i_rst ? 1'b0  : w_dmem_req;
    assign bus.dmem_we    = i_rst ? 1'b0  : w_dmem_we;
    assign bus.mem_width  = i_rst ? 3'b000 : r_f3;
    assign bus.alu_src_a  = i_rst ? 1'b0  : w_alu_src_a;
    assign bus.alu_src_b  = i_rst ? 1'b0  : w_alu_src_b;
    assign bus.alu_op     = i_rst ? 2'b00 : w_alu_op;
    assign bus.reg_write  = i_rst ? 1'b0  : w_reg_write;
    assign bus.wb_sel     = i_rst ? 2'b00 : w_wb_sel;
    assign bus.pc_write   = i_rst ? 1'b0  : w_pc_write;
    assign bus.pc_sel     = i_rst ? 2'b00 : w_pc_sel;
    assign bus.retire     = i_rst ? 1'b0  : w_retire;
    assign bus.trap       = i_rst ? 1'b0  : w_trap;
    assign bus.trap_cause = i_rst ? 2'b00 : r_cause;
    assign bus.state_o    = i_rst ? 3'd0  : r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm_if bus ();
    multicycle_control_fsm_if bus2 ();

    multicycle_control_fsm #(.TIMEOUT_CYCLES(16), .ILLEGAL_TRAP(1'b1)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .ILLEGAL_TRAP(1'b0)) u_dut2 (
        .i_clk (clk),
        .i_rst (rst2),
        .bus   (bus2)
    );

    typedef struct {
        logic [6:0] op;
        logic [1:0] alu_op;
        logic       src_a;
        logic       src_b;
        logic [1:0] wb;
        logic [1:0] pc;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset1();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic reset2();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        tick();
        #1;
        n_cmp++;
        if ({bus.imem_req, bus.ir_write, bus.dmem_req, bus.retire, bus.pc_write} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_enables: got %b want 00000",
                     {bus.imem_req, bus.ir_write, bus.dmem_req, bus.retire, bus.pc_write});
        end
        n_cmp++;
        if ({bus.trap, bus.trap_cause, bus.state_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_trap_state: got %b want 000000",
                     {bus.trap, bus.trap_cause, bus.state_o});
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.state_o, bus.imem_req, bus.ir_write, bus.mem_width} !== {3'd0, 1'b1, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL reset_release: got %b want 000100000",
                     {bus.state_o, bus.imem_req, bus.ir_write, bus.mem_width});
        end
    endtask

    task automatic test_add();
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        logic       exp_wb [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bus.opcode     = 7'b0110011;
        bus.funct3     = 3'b000;
        bus.imem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (bus.state_o !== exp_st[c]) begin
                n_err++;
                $display("FAIL add_state c=%0d: got %0d want %0d", c, bus.state_o, exp_st[c]);
            end
            n_cmp++;
            if ({bus.reg_write, bus.retire} !== {exp_wb[c], exp_wb[c]}) begin
                n_err++;
                $display("FAIL add_rw_retire c=%0d: got %b want %b", c,
                         {bus.reg_write, bus.retire}, {exp_wb[c], exp_wb[c]});
            end
            if (c == 3) begin
                n_cmp++;
                if ({bus.wb_sel, bus.pc_write, bus.pc_sel} !== 5'b00100) begin
                    n_err++;
                    $display("FAIL add_wb: got %b want 00100", {bus.wb_sel, bus.pc_write, bus.pc_sel});
                end
            end
            tick();
        end
        #1;
        n_cmp++;
        if (bus.state_o !== 3'd0) begin
            n_err++;
            $display("FAIL add_back_to_fetch: got %0d want 0", bus.state_o);
        end
    endtask

    task automatic test_load();
        logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        int n_ret = 0;
        bus.opcode     = 7'b0000011;
        bus.funct3     = 3'b010;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) bus.dmem_ready = 1'b1;
            #1;
            n_cmp++;
            if (bus.state_o !== exp_st[c]) begin
                n_err++;
                $display("FAIL lw_state c=%0d: got %0d want %0d", c, bus.state_o, exp_st[c]);
            end
            if (exp_st[c] == 3'd3) begin
                n_cmp++;
                if ({bus.dmem_req, bus.dmem_we, bus.mem_width, bus.alu_src_b} !== 6'b100101) begin
                    n_err++;
                    $display("FAIL lw_mem c=%0d: got %b want 100101", c,
                             {bus.dmem_req, bus.dmem_we, bus.mem_width, bus.alu_src_b});
                end
            end
            if (c == 7) begin
                n_cmp++;
                if ({bus.wb_sel, bus.reg_write} !== 3'b011) begin
                    n_err++;
                    $display("FAIL lw_wb: got %b want 011", {bus.wb_sel, bus.reg_write});
                end
            end
            n_ret += int'(bus.retire);
            tick();
        end
        bus.dmem_ready = 1'b0;
        #1;
        n_cmp++;
        if ((n_ret !== 1) || (bus.state_o !== 3'd0)) begin
            n_err++;
            $display("FAIL lw_retire_count: got %0d retires state %0d want 1 retire state 0",
                     n_ret, bus.state_o);
        end
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            bus.opcode       = 7'b1100011;
            bus.funct3       = 3'b000;
            bus.branch_taken = (t == 1);
            for (int c = 0; c < 3; c++) begin
                #1;
                n_cmp++;
                if ((bus.state_o !== 3'(c)) || (bus.reg_write !== 1'b0)) begin
                    n_err++;
                    $display("FAIL br_state t=%0d c=%0d: got state %0d rw %b want state %0d rw 0",
                             t, c, bus.state_o, bus.reg_write, c);
                end
                if (c == 2) begin
                    n_cmp++;
                    if ({bus.pc_write, bus.pc_sel, bus.retire, bus.alu_op} !==
                        {1'b1, (t == 1) ? 2'b01 : 2'b00, 1'b1, 2'b01}) begin
                        n_err++;
                        $display("FAIL br_exec t=%0d: got %b want %b", t,
                                 {bus.pc_write, bus.pc_sel, bus.retire, bus.alu_op},
                                 {1'b1, (t == 1) ? 2'b01 : 2'b00, 1'b1, 2'b01});
                    end
                end
                tick();
            end
        end
        bus.branch_taken = 1'b0;
    endtask

    task automatic test_exec_wb();
        vec_t tbl [5];
        tbl[0] = '{op: 7'b1101111, alu_op: 2'b00, src_a: 1'b0, src_b: 1'b0, wb: 2'b10, pc: 2'b10};
        tbl[1] = '{op: 7'b1100111, alu_op: 2'b00, src_a: 1'b0, src_b: 1'b1, wb: 2'b10, pc: 2'b11};
        tbl[2] = '{op: 7'b0110111, alu_op: 2'b00, src_a: 1'b0, src_b: 1'b0, wb: 2'b11, pc: 2'b00};
        tbl[3] = '{op: 7'b0010111, alu_op: 2'b00, src_a: 1'b1, src_b: 1'b1, wb: 2'b00, pc: 2'b00};
        tbl[4] = '{op: 7'b0010011, alu_op: 2'b10, src_a: 1'b0, src_b: 1'b1, wb: 2'b00, pc: 2'b00};
        for (int i = 0; i < 5; i++) begin
            bus.opcode = tbl[i].op;
            for (int c = 0; c < 4; c++) begin
                #1;
                n_cmp++;
                if (bus.state_o !== ((c == 3) ? 3'd4 : 3'(c))) begin
                    n_err++;
                    $display("FAIL xw_state op=%b c=%0d: got %0d", tbl[i].op, c, bus.state_o);
                end
                if (c == 2) begin
                    n_cmp++;
                    if ({bus.alu_op, bus.alu_src_a, bus.alu_src_b} !==
                        {tbl[i].alu_op, tbl[i].src_a, tbl[i].src_b}) begin
                        n_err++;
                        $display("FAIL xw_alu op=%b: got %b want %b", tbl[i].op,
                                 {bus.alu_op, bus.alu_src_a, bus.alu_src_b},
                                 {tbl[i].alu_op, tbl[i].src_a, tbl[i].src_b});
                    end
                end
                if (c == 3) begin
                    n_cmp++;
                    if ({bus.wb_sel, bus.pc_sel, bus.reg_write, bus.pc_write, bus.retire} !==
                        {tbl[i].wb, tbl[i].pc, 3'b111}) begin
                        n_err++;
                        $display("FAIL xw_wb op=%b: got %b want %b", tbl[i].op,
                                 {bus.wb_sel, bus.pc_sel, bus.reg_write, bus.pc_write, bus.retire},
                                 {tbl[i].wb, tbl[i].pc, 3'b111});
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_store_reset();
        bus.opcode     = 7'b0100011;
        bus.funct3     = 3'b001;
        bus.dmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (bus.state_o !== 3'(c)) begin
                n_err++;
                $display("FAIL sw_state c=%0d: got %0d want %0d", c, bus.state_o, c);
            end
            tick();
        end
        #1;
        n_cmp++;
        if ({bus.state_o, bus.dmem_req, bus.dmem_we, bus.mem_width} !== {3'd3, 2'b11, 3'b001}) begin
            n_err++;
            $display("FAIL sw_mem: got %b want 01111001",
                     {bus.state_o, bus.dmem_req, bus.dmem_we, bus.mem_width});
        end
        rst = 1'b1;
        bus.dmem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.dmem_req, bus.dmem_we, bus.retire, bus.pc_write} !== 4'b0000) begin
            n_err++;
            $display("FAIL sw_during_rst: got %b want 0000",
                     {bus.dmem_req, bus.dmem_we, bus.retire, bus.pc_write});
        end
        tick();
        rst = 1'b0;
        bus.dmem_ready = 1'b0;
        #1;
        n_cmp++;
        if ({bus.state_o, bus.retire, bus.mem_width} !== 7'b0) begin
            n_err++;
            $display("FAIL sw_after_rst: got %b want 0000000",
                     {bus.state_o, bus.retire, bus.mem_width});
        end
    endtask

    task automatic test_ecall();
        bus.opcode = 7'b1110011;
        for (int c = 0; c < 3; c++) tick();
        #1;
        n_cmp++;
        if ({bus.state_o, bus.trap, bus.trap_cause, bus.retire} !== {3'd5, 1'b1, 2'b10, 1'b0}) begin
            n_err++;
            $display("FAIL ecall_trap: got %b want 1011100",
                     {bus.state_o, bus.trap, bus.trap_cause, bus.retire});
        end
        reset1();
        #1;
        n_cmp++;
        if ({bus.trap, bus.trap_cause, bus.state_o} !== 6'b0) begin
            n_err++;
            $display("FAIL ecall_cleared: got %b want 000000", {bus.trap, bus.trap_cause, bus.state_o});
        end
    endtask

    task automatic test_illegal_trap();
        bus.opcode = 7'b1111111;
        tick();
        #1;
        n_cmp++;
        if ({bus.state_o, bus.retire, bus.pc_write} !== {3'd1, 2'b00}) begin
            n_err++;
            $display("FAIL ill_decode: got %b want 00100", {bus.state_o, bus.retire, bus.pc_write});
        end
        tick();
        for (int k = 0; k < 20; k++) begin
            #1;
            n_cmp++;
            if ({bus.state_o, bus.trap, bus.trap_cause, bus.imem_req, bus.pc_write, bus.retire} !==
                {3'd5, 1'b1, 2'b01, 3'b000}) begin
                n_err++;
                $display("FAIL ill_trap_hold k=%0d: got %b want 10110 1000", k,
                         {bus.state_o, bus.trap, bus.trap_cause, bus.imem_req, bus.pc_write, bus.retire});
            end
            tick();
        end
        reset1();
        #1;
        n_cmp++;
        if ({bus.state_o, bus.trap} !== 4'b0) begin
            n_err++;
            $display("FAIL ill_rst_exit: got %b want 0000", {bus.state_o, bus.trap});
        end
    endtask

    task automatic test_illegal_nop();
        reset2();
        bus2.opcode     = 7'b1111111;
        bus2.imem_ready = 1'b1;
        tick();
        #1;
        n_cmp++;
        if ({bus2.state_o, bus2.retire, bus2.pc_write, bus2.pc_sel, bus2.trap} !==
            {3'd1, 1'b1, 1'b1, 2'b00, 1'b0}) begin
            n_err++;
            $display("FAIL nop_decode: got %b want 0011100",
                     {bus2.state_o, bus2.retire, bus2.pc_write, bus2.pc_sel, bus2.trap});
        end
        bus2.imem_ready = 1'b0;
        tick();
        #1;
        n_cmp++;
        if ({bus2.state_o, bus2.trap, bus2.retire} !== 5'b0) begin
            n_err++;
            $display("FAIL nop_back_to_fetch: got %b want 00000", {bus2.state_o, bus2.trap, bus2.retire});
        end
    endtask

    task automatic test_timeout();
        reset2();
        bus2.imem_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if ({bus2.state_o, bus2.imem_req, bus2.trap} !== {3'd0, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL to_wait c=%0d: got %b want 00010", c,
                         {bus2.state_o, bus2.imem_req, bus2.trap});
            end
            tick();
        end
        #1;
        n_cmp++;
        if ({bus2.state_o, bus2.trap, bus2.trap_cause} !== {3'd5, 1'b1, 2'b11}) begin
            n_err++;
            $display("FAIL to_trap: got %b want 101111", {bus2.state_o, bus2.trap, bus2.trap_cause});
        end
        reset2();
        bus2.opcode = 7'b0110011;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) bus2.imem_ready = 1'b1;
            #1;
            n_cmp++;
            if ({bus2.state_o, bus2.trap} !== 4'b0) begin
                n_err++;
                $display("FAIL to_race_wait c=%0d: got %b want 0000", c, {bus2.state_o, bus2.trap});
            end
            tick();
        end
        bus2.imem_ready = 1'b0;
        #1;
        n_cmp++;
        if ({bus2.state_o, bus2.trap, bus2.trap_cause} !== {3'd1, 3'b000}) begin
            n_err++;
            $display("FAIL to_race_ready_wins: got %b want 001000",
                     {bus2.state_o, bus2.trap, bus2.trap_cause});
        end
    endtask

    initial begin
        bus.opcode        = 7'd0;
        bus.funct3        = 3'd0;
        bus.imem_ready    = 1'b0;
        bus.dmem_ready    = 1'b0;
        bus.branch_taken  = 1'b0;
        bus2.opcode       = 7'd0;
        bus2.funct3       = 3'd0;
        bus2.imem_ready   = 1'b0;
        bus2.dmem_ready   = 1'b0;
        bus2.branch_taken = 1'b0;

        test_reset();
        test_add();
        test_load();
        test_branch();
        test_exec_wb();
        test_store_reset();
        test_ecall();
        test_illegal_trap();
        test_illegal_nop();
        test_timeout();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequential RV32I control unit for the multi-cycle datapath; replaces the single-cycle opcode decoder.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and handshakes with instruction and data memories that have variable latency.
- Adds a bus-timeout watchdog, a sticky trap state for illegal opcodes, ECALL/EBREAK and timeouts, and a per-instruction retire pulse.

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles for imem_ready/dmem_ready; 0 disables the watchdog.
- ILLEGAL_TRAP, 1: 1 = unknown opcode enters TRAP; 0 = unknown opcode retires as a NOP.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instruction-register bits [6:0], valid from DECODE onward.
- funct3  in  3  instruction-register bits [14:12].
- imem_ready  in  1  instruction memory returns data this cycle.
- dmem_ready  in  1  data memory completes access this cycle.
- branch_taken  in  1  comparator result, valid in EXEC.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load the instruction register.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write enable (store).
- mem_width  out  3  registered funct3, drives load/store width.
- alu_src_a  out  1  0 = rs1, 1 = pc.
- alu_src_b  out  1  0 = rs2, 1 = imm.
- alu_op  out  2  00 ADD, 01 SUB, 10 funct-decoded.
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  00 alu, 01 mem, 10 pc+4, 11 imm.
- pc_write  out  1  update PC.
- pc_sel  out  2  00 pc+4, 01 branch target, 10 jal target, 11 jalr target.
- retire  out  1  one-cycle pulse per completed instruction.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  01 illegal, 10 ecall/ebreak, 11 bus timeout.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset: while rst is high, all outputs are forced to 0 and trap_cause is 00. On the next edge the state is FETCH, the wait counter is 0 and the opcode/funct3 registers are 0.
- Reset mid-operation: a MEM access or WB in progress is abandoned; no write or retire occurs.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1 in that cycle, then go to DECODE.
  - Otherwise the wait counter increments.
- DECODE:
  - Latch opcode into opc_q and funct3 into f3_q; mem_width = f3_q.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011.
  - A legal opcode goes to EXEC.
  - An illegal opcode goes to TRAP (cause 01) when ILLEGAL_TRAP=1. When ILLEGAL_TRAP=0 it asserts pc_write=1, pc_sel=00, retire=1 and returns to FETCH.
- EXEC: alu_op, alu_src_a and alu_src_b are set per opcode:
  - R-type: 10/0/0. I-type: 10/0/1. Load/store: 00/0/1.
  - Branch: 01/0/0, plus pc_write=1, pc_sel = branch_taken ? 01 : 00, retire=1, go to FETCH.
  - AUIPC: 00/1/1. JALR: 00/0/1. JAL and LUI: 00/0/0.
  - Load/store go to MEM.
  - FENCE: pc_write=1, pc_sel=00, retire=1, go to FETCH.
  - SYSTEM: go to TRAP (cause 10).
  - All other legal opcodes go to WB.
- MEM:
  - dmem_req=1, dmem_we = (opc_q == store); ALU controls are held from EXEC.
  - On dmem_ready, load: go to WB.
  - On dmem_ready, store: pc_write=1, pc_sel=00, retire=1, go to FETCH.
- WB:
  - reg_write=1 and pc_write=1, retire=1, then go to FETCH.
  - wb_sel: load 01, JAL/JALR 10, LUI 11, otherwise 00.
  - pc_sel: JAL 10, JALR 11, otherwise 00.
- Watchdog (TIMEOUT_CYCLES > 0):
  - The counter clears on every state change.
  - In FETCH or MEM, if the counter equals TIMEOUT_CYCLES and ready is still low, go to TRAP (cause 11).
  - If ready arrives in the same cycle as the timeout, ready wins.
  - Counter width is clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.
- TRAP:
  - trap=1 and trap_cause is held; all enables are 0.
  - Only rst exits TRAP.
- Timing: at most one retire per instruction.
  - Latency with zero-wait memories: branch/FENCE 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4, store 4, load 5.
  - Each memory wait cycle adds 1.

Test Plan:
- ADD (opcode 0110011), imem_ready high every cycle -> states 0,1,2,4,0; reg_write=1, wb_sel=00, retire=1 in cycle 4 only.
- LW with dmem_ready low for 3 cycles -> MEM holds dmem_req=1, dmem_we=0 for 4 cycles; WB wb_sel=01; total latency 8 cycles.
- BEQ with branch_taken=1, then again with 0 -> EXEC pc_write=1 with pc_sel=01, then 00; reg_write never asserted.
- Opcode 1111111: with ILLEGAL_TRAP=1 -> trap=1, cause=01, held for 20 cycles until rst. With ILLEGAL_TRAP=0 -> retire=1, pc_sel=00, back to FETCH.
- TIMEOUT_CYCLES=4, imem_ready held low -> TRAP with cause=11 after exactly 5 FETCH cycles. In a separate run, ready arriving on the 5th cycle -> DECODE, no trap.
- SW with rst asserted on the first MEM cycle -> dmem_req=0 during rst, no retire, state 0 after release.
